bcd_score_counter: RTL
======================

BCD_SCORE_COUNTER -- requirements
Module: bcd_score_counter

Interface
REQ-001 Parameter DIGITS, default 3, is the number of BCD digits; legal range is 1..8.
REQ-002 Parameter WRAP, default 1: 1 = wrap at the boundaries; 0 = saturate at the boundaries.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inc  input  1  increment request, level; acts on its rising edge only.
REQ-006 dec  input  1  decrement request, level; acts on its rising edge only.
REQ-007 clr  input  1  synchronous clear of the count, level-sensitive.
REQ-008 digits  output  4*DIGITS  BCD count; digit 0 (least significant) occupies bits [3:0].
REQ-009 blank  output  DIGITS  leading-zero blank mask; bit i set = digit i is a leading zero.
REQ-010 ovf  output  1  one-cycle pulse when an increment wraps or saturates at the maximum.
REQ-011 unf  output  1  one-cycle pulse when a decrement wraps or saturates at zero.

Function
REQ-012 The block SHALL register inc and dec each cycle, forming inc_edge = inc & ~inc_q and dec_edge = dec & ~dec_q.
REQ-013 The count SHALL update at the same clock edge at which the edge is detected; digits SHALL show the new value after that edge (latency 1 edge).
REQ-014 Priority SHALL be: reset > clr > (inc_edge & dec_edge, which makes no change) > inc_edge > dec_edge.
REQ-015 An increment SHALL add 1 in BCD; a digit at 9 SHALL go to 0 and carry into the next digit.
REQ-016 An increment at all-9s SHALL give all-0s when WRAP=1, or hold all-9s when WRAP=0; ovf SHALL pulse in both cases.
REQ-017 A decrement SHALL subtract 1 in BCD; a digit at 0 SHALL go to 9 and borrow from the next digit.
REQ-018 A decrement at all-0s SHALL give all-9s when WRAP=1, or hold all-0s when WRAP=0; unf SHALL pulse in both cases.
REQ-019 ovf and unf SHALL be registered and high for exactly one cycle per event.
REQ-020 clr SHALL zero the count and SHALL NOT pulse ovf or unf.
REQ-021 clr SHALL NOT clear inc_q or dec_q, so a level held through clr produces no new edge.
REQ-022 blank bit i (i>0) SHALL be 1 when digit i and all higher digits are 0.
REQ-023 blank bit 0 SHALL always be 0.
REQ-024 blank SHALL be combinational from the registered count.
REQ-025 Every digit value SHALL stay in 0..9 at all times; non-BCD codes are unreachable.

Reset
REQ-026 On reset the block SHALL set digits to 0, ovf to 0, unf to 0, inc_q to 0 and dec_q to 0; blank SHALL therefore read all-1s except bit 0.
REQ-027 Reset asserted during an edge cycle SHALL win; the pending edge SHALL be discarded.
REQ-028 If inc is still high after reset is released, it SHALL count once, because inc_q was cleared by reset.

Structure
REQ-029 Shared package bcd_pkg SHALL hold typedef bcd_t (4-bit) and constants BCD_MAX=9 and BCD_MIN=0.
REQ-030 Sub-module bcd_digit SHALL implement one digit with en, up/down, carry/borrow in and carry/borrow out.
REQ-031 The top level SHALL instantiate DIGITS copies of bcd_digit in a generate chain.
REQ-032 Boundary detection (all-9s / all-0s) SHALL use the final carry/borrow out of the chain.

Verification (DIGITS=3)
REQ-033 Reset, then hold inc high for 5 cycles -> count 001, exactly one increment.
REQ-034 From 099, pulse inc -> 100 one edge later; blank=000.
REQ-035 WRAP=1: from 999, pulse inc -> 000 and one-cycle ovf; WRAP=0: from 999, pulse inc -> stays 999 with one-cycle ovf.
REQ-036 From 000, pulse dec -> 999 with unf (WRAP=1), or stays 000 with unf (WRAP=0); from 100, pulse dec -> 099 and blank=100.
REQ-037 From 042, raise inc and dec in the same cycle -> stays 042 with no pulses; at 042, raise clr and inc together -> 000 with no ovf.
REQ-038 At 057, assert reset in the same cycle as an inc edge -> 000; blank=110; ovf=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD score counter.
//   bcd_t    : one 4-bit BCD digit
//   BCD_MAX  : largest legal digit value (9)
//   BCD_MIN  : smallest legal digit value (0)
//   bcd_step : next value of a single digit when it is stepped up or down,
//              wrapping 9->0 (up) and 0->9 (down); the wrap is what generates
//              the carry/borrow into the next digit.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  function automatic bcd_t bcd_step(input bcd_t d, input logic up);
    bcd_t r;
    if (up) begin
      r = (d == BCD_MAX) ? BCD_MIN : d + 4'd1;
    end else begin
      r = (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit of the score counter chain.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset, forces digit to 0
//   clr_i   : synchronous clear, forces digit to 0
//   en_i    : global step enable for this cycle
//   up_i    : direction, 1 = increment, 0 = decrement
//   cin_i   : carry (up) / borrow (down) in from the lower digit
//   digit_o : registered digit value
//   cout_o  : carry / borrow out to the next digit
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  input  logic up_i,
  input  logic cin_i,
  output bcd_t digit_o,
  output logic cout_o
);

  bcd_t digit_q;
  bcd_t digit_d;
  logic at_limit;

  // A digit passes the carry/borrow on only when it is itself about to wrap.
  assign at_limit = up_i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
  assign cout_o   = cin_i & at_limit;
  assign digit_o  = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = BCD_MIN;
    end else if (en_i && cin_i) begin
      digit_d = bcd_step(digit_q, up_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD up/down score counter with edge-triggered inc/dec,
// wrap-or-saturate boundaries, overflow/underflow pulses and a
// leading-zero blank mask.
// Parameters:
//   DIGITS : number of BCD digits (1..8)
//   WRAP   : 1 = wrap at 999../000.., 0 = saturate there
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   inc    : increment request level, acts on its rising edge
//   dec    : decrement request level, acts on its rising edge
//   clr    : synchronous clear of the count (level)
//   digits : BCD count, digit 0 in bits [3:0]
//   blank  : leading-zero mask, bit i set = digit i is a leading zero
//   ovf    : one-cycle pulse on increment at the maximum
//   unf    : one-cycle pulse on decrement at zero
module bcd_score_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf,
  output logic                  unf
);

  logic inc_q, dec_q;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic inc_edge, dec_edge;
  logic step, up, at_bound, en;
  logic all_zero;
  logic [DIGITS:0] carry;
  bcd_t dig [DIGITS];

  assign inc_edge = inc & ~inc_q;
  assign dec_edge = dec & ~dec_q;

  // Simultaneous inc and dec edges cancel; clr overrides both.
  assign step = ~clr & (inc_edge ^ dec_edge);
  assign up   = inc_edge;

  // Digit 0 always sees a carry-in; the chain decides how far it ripples.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (clr),
      .en_i    (en),
      .up_i    (up),
      .cin_i   (carry[g]),
      .digit_o (dig[g]),
      .cout_o  (carry[g+1])
    );
    assign digits[4*g +: 4] = dig[g];
  end

  // Carry out of the top digit means every digit is at its limit
  // (all 9s going up, all 0s going down).
  assign at_bound = carry[DIGITS];

  // In saturate mode the chain is frozen at the boundary.
  assign en = step & ((WRAP != 0) | ~at_bound);

  assign ovf_d = step &  up & at_bound;
  assign unf_d = step & ~up & at_bound;

  // clr deliberately leaves inc_q/dec_q alone so a held level gives no new edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;

  // Scan from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    all_zero = 1'b1;
    blank    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (dig[i] == BCD_MIN);
      if (i > 0) begin
        blank[i] = all_zero;
      end
    end
  end

endmodule
